accumulator_ctrl_mc: RTL and testbench

- Parametrised, multi-channel accumulate / final-add / round / push sequencer for the FIR datapath.
- Sits after the multiplier. It accumulates NUM_TAPS products per output sample for each of NUM_CH interleaved channels.
- It drives the coefficient-select index back to the multiplier mux.
- Each completed sum is rounded and saturated to OUT_W, then pushed downstream with a PushOut/StopOut handshake.

---
 rtl/accumulator_ctrl_mc.sv | 159 +++++++++++++++
 tb/tb_accumulator_ctrl_mc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/accumulator_ctrl_mc.sv
// Multi-channel FIR accumulate / final-add / round / push sequencer.
// Per-channel partial sums feed a 3-cycle result pipe with a one-deep overflow slot.
module accumulator_ctrl_mc #(
    parameter int PROD_W     = 32,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 16,
    parameter int FRAC_BITS  = 15,
    parameter int NUM_TAPS   = 4,
    parameter int NUM_CH     = 2,
    parameter int ROUND_MODE = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAP_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PushIn,
    input  logic [PROD_W-1:0] ProdIn,
    input  logic [CH_W-1:0]   ChIn,
    output logic              InReady,
    output logic [TAP_W-1:0]  TapSel,
    output logic              PushOut,
    output logic [OUT_W-1:0]  DataOut,
    output logic [CH_W-1:0]   ChOut,
    input  logic              StopOut,
    output logic              Err
);
    localparam int NENT = 1 << CH_W;
    localparam logic [ACC_W:0] RND =
        (ROUND_MODE != 0) ? ((ACC_W+1)'(1) << (FRAC_BITS-1)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_FADD, S_ROUND, S_PUSH} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q [NENT];
    logic [TAP_W-1:0]          tap_q [NENT];
    logic                      pend_vld_q, pend_vld_d;
    logic signed [ACC_W-1:0]   pend_sum_q, pend_sum_d;
    logic [CH_W-1:0]           pend_ch_q, pend_ch_d;
    logic signed [ACC_W:0]     work_q, work_d;
    logic [CH_W-1:0]           wch_q, wch_d;
    logic [OUT_W-1:0]          dout_q, dout_d;
    logic [CH_W-1:0]           chout_q, chout_d;
    logic                      err_q;

    logic                      legal, accept, acc_ok, is_final, fin;
    logic                      push_done, free, pend_load, fin_to_work;
    logic [CH_W-1:0]           idx;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W:0]     shifted;
    logic [OUT_W-1:0]          sat_val;

    // Illegal channels are redirected to entry 0 for reads but never written.
    assign legal     = (32'(ChIn) < 32'(NUM_CH));
    assign idx       = legal ? ChIn : '0;
    assign accept    = PushIn & InReady;
    assign acc_ok    = accept & legal;
    assign is_final  = (tap_q[idx] == TAP_W'(NUM_TAPS-1));
    assign fin       = acc_ok & is_final;
    assign sum       = acc_q[idx] + ACC_W'($signed(ProdIn));

    assign push_done   = (state_q == S_PUSH) && !StopOut;
    assign free        = (state_q == S_IDLE) || push_done;
    assign pend_load   = free && pend_vld_q;
    assign fin_to_work = fin && free && !pend_vld_q;

    assign shifted = work_q >>> FRAC_BITS;
    always_comb begin
        sat_val = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        wch_d      = wch_q;
        pend_vld_d = pend_vld_q;
        pend_sum_d = pend_sum_q;
        pend_ch_d  = pend_ch_q;
        dout_d     = dout_q;
        chout_d    = chout_q;
        case (state_q)
            S_FADD: begin
                work_d  = work_q + RND;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                dout_d  = sat_val;
                chout_d = wch_q;
                state_d = S_PUSH;
            end
            S_PUSH:  if (!StopOut) state_d = S_IDLE;
            default: ;
        endcase
        // The pending result always takes priority over a same-cycle final sum.
        if (pend_load) begin
            work_d     = {pend_sum_q[ACC_W-1], pend_sum_q};
            wch_d      = pend_ch_q;
            pend_vld_d = 1'b0;
            state_d    = S_FADD;
        end else if (fin_to_work) begin
            work_d  = {sum[ACC_W-1], sum};
            wch_d   = ChIn;
            state_d = S_FADD;
        end
        if (fin && !fin_to_work) begin
            pend_vld_d = 1'b1;
            pend_sum_d = sum;
            pend_ch_d  = ChIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            wch_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_sum_q <= '0;
            pend_ch_q  <= '0;
            dout_q     <= '0;
            chout_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NENT; i++) begin
                acc_q[i] <= '0;
                tap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            wch_q      <= wch_d;
            pend_vld_q <= pend_vld_d;
            pend_sum_q <= pend_sum_d;
            pend_ch_q  <= pend_ch_d;
            dout_q     <= dout_d;
            chout_q    <= chout_d;
            if (accept && !legal) err_q <= 1'b1;
            if (acc_ok) begin
                if (is_final) begin
                    acc_q[idx] <= '0;
                    tap_q[idx] <= '0;
                end else begin
                    acc_q[idx] <= sum;
                    tap_q[idx] <= tap_q[idx] + TAP_W'(1);
                end
            end
        end
    end

    assign InReady = !pend_vld_q;
    assign TapSel  = legal ? tap_q[idx] : '0;
    assign PushOut = (state_q == S_PUSH);
    assign DataOut = dout_q;
    assign ChOut   = chout_q;
    assign Err     = err_q;
endmodule

// File: tb/tb_accumulator_ctrl_mc.sv
// Directed bench: a 3-channel round-half-up instance plus a 1-channel truncating
// instance sharing the same product stream.
module tb_accumulator_ctrl_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic        PushIn;
    logic [31:0] ProdIn;
    logic [1:0]  ChIn;
    logic        StopOut;

    logic        a_rdy, a_po, a_err;
    logic [1:0]  a_tap, a_co;
    logic [15:0] a_do;
    logic        b_rdy, b_po, b_err;
    logic [1:0]  b_tap;
    logic [0:0]  b_co;
    logic [15:0] b_do;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    accumulator_ctrl_mc #(.NUM_CH(3), .ROUND_MODE(1)) u_a (
        .clk(clk), .reset(reset), .PushIn(PushIn), .ProdIn(ProdIn), .ChIn(ChIn),
        .InReady(a_rdy), .TapSel(a_tap), .PushOut(a_po), .DataOut(a_do),
        .ChOut(a_co), .StopOut(StopOut), .Err(a_err)
    );

    accumulator_ctrl_mc #(.NUM_CH(1), .ROUND_MODE(0)) u_b (
        .clk(clk), .reset(reset), .PushIn(PushIn), .ProdIn(ProdIn), .ChIn(1'b0),
        .InReady(b_rdy), .TapSel(b_tap), .PushOut(b_po), .DataOut(b_do),
        .ChOut(b_co), .StopOut(StopOut), .Err(b_err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] v);
        PushIn = 1'b1; ChIn = ch; ProdIn = v;
        tick();
        PushIn = 1'b0;
    endtask

    task automatic push_chk(input logic [1:0] ch, input logic [31:0] v, input int tap);
        PushIn = 1'b1; ChIn = ch; ProdIn = v;
        #1;
        chk("tapsel", int'(a_tap), tap);
        tick();
        PushIn = 1'b0;
    endtask

    task automatic wait_push();
        int n = 0;
        while (!a_po && n < 10) begin
            tick();
            n++;
        end
        chk("push_seen", int'(a_po), 1);
    endtask

    initial begin
        reset = 1'b1; PushIn = 1'b0; ProdIn = '0; ChIn = '0; StopOut = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_po",  int'(a_po), 0);
        chk("rst_do",  int'(a_do), 0);
        chk("rst_co",  int'(a_co), 0);
        chk("rst_err", int'(a_err), 0);
        chk("rst_rdy", int'(a_rdy), 1);
        reset = 1'b0;
        tick();

        // Basic rounding and exact 3-cycle latency
        push(0, 32'd16384); push(0, 32'd16384); push(0, 32'd16384); push(0, 32'd0);
        chk("lat_n1", int'(a_po), 0);
        tick();
        chk("lat_n2", int'(a_po), 0);
        tick();
        chk("lat_n3", int'(a_po), 1);
        chk("round_up", int'($signed(a_do)), 2);
        chk("round_ch", int'(a_co), 0);
        chk("trunc_po", int'(b_po), 1);
        chk("trunc", int'($signed(b_do)), 1);
        tick();
        chk("idle_po", int'(a_po), 0);
        chk("idle_hold", int'($signed(a_do)), 2);

        // Negative and saturation
        repeat (3) push(0, 32'hFFFF_C000);
        push(0, 32'd0);
        wait_push();
        chk("neg", int'($signed(a_do)), -1);
        tick();
        repeat (4) push(0, 32'h7FFF_FFFF);
        wait_push();
        chk("sat_pos", int'($signed(a_do)), 32767);
        tick();
        repeat (4) push(0, 32'h8000_0000);
        wait_push();
        chk("sat_neg", int'($signed(a_do)), -32768);
        tick();

        // Channel interleave: ch1 finishes while ch0 is in flight
        for (int i = 0; i < 4; i++) begin
            push_chk(0, 32'd32768, i);
            push_chk(1, 32'hFFFF_8000, i);
        end
        chk("il_pend_rdy", int'(a_rdy), 0);
        tick();
        chk("il_po0", int'(a_po), 1);
        chk("il_do0", int'($signed(a_do)), 4);
        chk("il_co0", int'(a_co), 0);
        tick();
        chk("il_rdy_back", int'(a_rdy), 1);
        chk("il_gap", int'(a_po), 0);
        tick(); tick();
        chk("il_po1", int'(a_po), 1);
        chk("il_do1", int'($signed(a_do)), -4);
        chk("il_co1", int'(a_co), 1);
        tick();

        // Backpressure with pending slot full
        StopOut = 1'b1;
        repeat (4) push(0, 32'd32768);
        repeat (4) push(1, 32'hFFFF_8000);
        chk("bp_rdy", int'(a_rdy), 0);
        chk("bp_po", int'(a_po), 1);
        PushIn = 1'b1; ChIn = 2'd0; ProdIn = 32'd12345;
        repeat (8) tick();
        chk("bp_rdy_hold", int'(a_rdy), 0);
        chk("bp_po_hold", int'(a_po), 1);
        chk("bp_do_hold", int'($signed(a_do)), 4);
        chk("bp_co_hold", int'(a_co), 0);
        PushIn = 1'b0; StopOut = 1'b0;
        tick();
        chk("bp_rdy_rel", int'(a_rdy), 1);
        chk("bp_gap", int'(a_po), 0);
        tick(); tick();
        chk("bp_po1", int'(a_po), 1);
        chk("bp_do1", int'($signed(a_do)), -4);
        chk("bp_co1", int'(a_co), 1);
        tick();
        repeat (4) push(0, 32'd16384);
        wait_push();
        chk("bp_no_accept", int'($signed(a_do)), 2);
        tick();

        // Reset during ROUND discards partials and the in-flight result
        push(1, 32'd32768); push(1, 32'd32768);
        repeat (4) push(0, 32'd16384);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_po", int'(a_po), 0);
        tick();
        chk("mid_rst_po2", int'(a_po), 0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push_chk(1, 32'd32768, i);
        wait_push();
        chk("post_rst_do", int'($signed(a_do)), 4);
        chk("post_rst_co", int'(a_co), 1);
        tick();

        // Illegal channel
        push_chk(0, 32'd16384, 0);
        push_chk(0, 32'd16384, 1);
        push_chk(3, 32'd99999, 0);
        chk("err_set", int'(a_err), 1);
        push_chk(0, 32'd16384, 2);
        push_chk(0, 32'd16384, 3);
        wait_push();
        chk("err_do", int'($signed(a_do)), 2);
        chk("err_co", int'(a_co), 0);
        tick();
        chk("err_sticky", int'(a_err), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
